decoder2x4_seq: RTL and testbench



---
 rtl/decoder2x4_seq_pkg.sv | 21 ++
 rtl/decoder2x4.sv | 17 +
 rtl/decoder2x4_seq.sv | 108 ++++++++++
 tb/tb_decoder2x4_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder2x4_seq_pkg.sv
// Shared definitions for the registered 2-to-4 decoder: widths, FSM state
// encodings and the counter type.
package decoder2x4_seq_pkg;

    localparam int CODE_W   = 2;
    localparam int ONEHOT_W = 4;
    localparam int CNT_W    = 8;

    // FSM encodings; the unused 2'b11 pattern recovers to ST_IDLE.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HOLD = 2'b01;
    localparam logic [1:0] ST_GAP  = 2'b10;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counter preload for a phase of n cycles; a zero-length phase loads 0.
    function automatic cnt_t phase_load(input int n);
        return (n > 0) ? cnt_t'(n - 1) : '0;
    endfunction

endpackage

// File: rtl/decoder2x4.sv
// Combinational 2-to-4 one-hot decoder; the counterpart of the 4-to-2
// encoder and usable on its own.
module decoder2x4
    import decoder2x4_seq_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < ONEHOT_W; gi++) begin : g_line
            assign onehot[gi] = (code == CODE_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/decoder2x4_seq.sv
// Registered 2-to-4 one-hot decoder with valid/ready intake: each accepted
// code drives its one-hot line for HOLD cycles, pulses done, then idles GAP cycles.
module decoder2x4_seq
    import decoder2x4_seq_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int GAP  = 1
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [CODE_W-1:0]   in_code,
    output logic                in_ready,
    output logic [ONEHOT_W-1:0] out,
    output logic                busy,
    output logic                done
);

    // Out-of-range parameters stop elaboration rather than silently wrapping
    // the 8-bit counter.
    generate
        if ((HOLD < 1) || (HOLD > 255) || (GAP < 0) || (GAP > 255)) begin : g_param_error
            $fatal(1, "decoder2x4_seq: HOLD must be 1..255 and GAP 0..255");
        end
    endgenerate

    localparam cnt_t HOLD_LOAD = phase_load(HOLD);
    localparam cnt_t GAP_LOAD  = phase_load(GAP);
    localparam bit   HAS_GAP   = (GAP > 0);

    logic [1:0]          state_reg, state_next;
    cnt_t                cnt_reg, cnt_next;
    logic [ONEHOT_W-1:0] out_reg, out_next;
    logic                done_reg, done_next;
    logic [ONEHOT_W-1:0] dec_onehot;

    decoder2x4 u_dec (
        .code   (in_code),
        .onehot (dec_onehot)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        out_next   = out_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                out_next = '0;
                if (in_valid) begin
                    state_next = ST_HOLD;
                    cnt_next   = HOLD_LOAD;
                    out_next   = dec_onehot;
                end
            end
            ST_HOLD: begin
                if (cnt_reg == '0) begin
                    out_next  = '0;
                    done_next = 1'b1;
                    // With no gap the block is ready again on the done cycle.
                    if (HAS_GAP) begin
                        state_next = ST_GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg - cnt_t'(1);
                end
            end
            ST_GAP: begin
                out_next = '0;
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - cnt_t'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                out_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            out_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
        end
    end

    assign in_ready = (state_reg == ST_IDLE);
    assign busy     = (state_reg != ST_IDLE);
    assign out      = out_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_decoder2x4_seq.sv
// Directed bench for decoder2x4_seq: one instance with HOLD=4/GAP=1 and one
// with HOLD=1/GAP=0, sharing clock and reset.
module tb_decoder2x4_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid_a, in_valid_b;
    logic [1:0] in_code_a, in_code_b;
    logic       in_ready_a, in_ready_b;
    logic [3:0] out_a, out_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int done_cnt_a = 0;

    always #5 clk = ~clk;

    decoder2x4_seq #(.HOLD(4), .GAP(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_code(in_code_a),
        .in_ready(in_ready_a), .out(out_a), .busy(busy_a), .done(done_a)
    );

    decoder2x4_seq #(.HOLD(1), .GAP(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_code(in_code_b),
        .in_ready(in_ready_b), .out(out_b), .busy(busy_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
        if (done_a) done_cnt_a++;
    endtask

    // Ticks until an edge with in_ready_a high has passed (bounded).
    task automatic wait_accept_a(output int acc_edge, output bit ok);
        bit rdy;
        ok = 1'b0;
        acc_edge = -1;
        for (int n = 0; n < 20 && !ok; n++) begin
            rdy = in_ready_a;
            tick();
            if (rdy) begin
                ok = 1'b1;
                acc_edge = edge_cnt;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid_a = 1'b0; in_code_a = 2'd0;
        in_valid_b = 1'b0; in_code_b = 2'd0;
        tick();
        tick();
        total++;
        if ({out_a, in_ready_a, busy_a, done_a} !== 7'b0000_1_0_0) begin
            bad++;
            $display("FAIL reset_hold_a: got out=%b rdy=%b busy=%b done=%b, want 0000 1 0 0",
                     out_a, in_ready_a, busy_a, done_a);
        end
        reset = 1'b0;
        tick();
        total++;
        if ({out_a, in_ready_a, busy_a, done_a} !== 7'b0000_1_0_0) begin
            bad++;
            $display("FAIL reset_idle_a: got out=%b rdy=%b busy=%b done=%b, want 0000 1 0 0",
                     out_a, in_ready_a, busy_a, done_a);
        end
        total++;
        if ({out_b, in_ready_b, busy_b, done_b} !== 7'b0000_1_0_0) begin
            bad++;
            $display("FAIL reset_idle_b: got out=%b rdy=%b busy=%b done=%b, want 0000 1 0 0",
                     out_b, in_ready_b, busy_b, done_b);
        end
    endtask

    task automatic test_single();
        in_code_a  = 2'd2;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        $display("single: accept code=2 at edge %0d", edge_cnt);
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({out_a, done_a, in_ready_a, busy_a} !== 7'b0100_0_0_1) begin
                bad++;
                $display("FAIL single_hold[%0d]: got out=%b done=%b rdy=%b busy=%b, want 0100 0 0 1",
                         k, out_a, done_a, in_ready_a, busy_a);
            end
            tick();
        end
        total++;
        if ({out_a, done_a, in_ready_a} !== 6'b0000_1_0) begin
            bad++;
            $display("FAIL single_done: got out=%b done=%b rdy=%b, want 0000 1 0",
                     out_a, done_a, in_ready_a);
        end
        tick();
        total++;
        if ({out_a, done_a, in_ready_a, busy_a} !== 7'b0000_0_1_0) begin
            bad++;
            $display("FAIL single_gap_end: got out=%b done=%b rdy=%b busy=%b, want 0000 0 1 0",
                     out_a, done_a, in_ready_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        int  prev_edge;
        int  acc_edge;
        bit  ok;
        logic [3:0] exp;
        prev_edge = -1;
        done_cnt_a = 0;
        in_valid_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_code_a = 2'(c);
            exp = 4'b0001 << c;
            wait_accept_a(acc_edge, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL b2b_accept[%0d]: got no transfer within 20 edges, want one", c);
            end
            $display("b2b: accept code=%0d at edge %0d", c, acc_edge);
            if (c > 0) begin
                total++;
                if (acc_edge - prev_edge != 6) begin
                    bad++;
                    $display("FAIL b2b_spacing[%0d]: got %0d edges, want 6", c, acc_edge - prev_edge);
                end
            end
            prev_edge = acc_edge;
            for (int k = 0; k < 3; k++) begin
                total++;
                if (out_a !== exp) begin
                    bad++;
                    $display("FAIL b2b_out[%0d.%0d]: got %b, want %b", c, k, out_a, exp);
                end
                tick();
            end
            total++;
            if (out_a !== exp) begin
                bad++;
                $display("FAIL b2b_out_last[%0d]: got %b, want %b", c, out_a, exp);
            end
        end
        in_valid_a = 1'b0;
        tick();
        tick();
        total++;
        if (done_cnt_a != 4) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d, want 4", done_cnt_a);
        end
    endtask

    task automatic test_gap0();
        in_code_b  = 2'd3;
        in_valid_b = 1'b1;
        tick();
        $display("gap0: accept code=3 at edge %0d", edge_cnt);
        total++;
        if ({out_b, in_ready_b, done_b} !== 6'b1000_0_0) begin
            bad++;
            $display("FAIL gap0_hold: got out=%b rdy=%b done=%b, want 1000 0 0", out_b, in_ready_b, done_b);
        end
        in_code_b = 2'd1;
        tick();
        total++;
        if ({out_b, in_ready_b, done_b} !== 6'b0000_1_1) begin
            bad++;
            $display("FAIL gap0_done: got out=%b rdy=%b done=%b, want 0000 1 1", out_b, in_ready_b, done_b);
        end
        tick();
        $display("gap0: accept code=1 at edge %0d", edge_cnt);
        in_valid_b = 1'b0;
        total++;
        if ({out_b, in_ready_b, done_b} !== 6'b0010_0_0) begin
            bad++;
            $display("FAIL gap0_second: got out=%b rdy=%b done=%b, want 0010 0 0", out_b, in_ready_b, done_b);
        end
        tick();
        tick();
        total++;
        if ({out_b, in_ready_b, busy_b, done_b} !== 7'b0000_1_0_0) begin
            bad++;
            $display("FAIL gap0_idle: got out=%b rdy=%b busy=%b done=%b, want 0000 1 0 0",
                     out_b, in_ready_b, busy_b, done_b);
        end
    endtask

    task automatic test_stall();
        int acc0;
        int acc1;
        bit ok;
        in_code_a  = 2'd3;
        in_valid_a = 1'b1;
        tick();
        acc0 = edge_cnt;
        $display("stall: accept code=3 at edge %0d", acc0);
        in_code_a = 2'd1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_a !== 4'b1000) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got %b, want 1000", k, out_a);
            end
            tick();
        end
        wait_accept_a(acc1, ok);
        $display("stall: accept code=1 at edge %0d", acc1);
        total++;
        if (!ok || (acc1 - acc0) != 6) begin
            bad++;
            $display("FAIL stall_spacing: got ok=%0d spacing=%0d, want ok=1 spacing=6", ok, acc1 - acc0);
        end
        total++;
        if (out_a !== 4'b0010) begin
            bad++;
            $display("FAIL stall_out: got %b, want 0010", out_a);
        end
        in_valid_a = 1'b0;
    endtask

    task automatic test_async_reset();
        tick();
        done_cnt_a = 0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({out_a, busy_a, in_ready_a, done_a} !== 7'b0000_0_1_0) begin
            bad++;
            $display("FAIL async_reset: got out=%b busy=%b rdy=%b done=%b, want 0000 0 1 0",
                     out_a, busy_a, in_ready_a, done_a);
        end
        tick();
        reset = 1'b0;
        in_code_a  = 2'd0;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        $display("async: accept code=0 at edge %0d", edge_cnt);
        total++;
        if (out_a !== 4'b0001) begin
            bad++;
            $display("FAIL async_first_accept: got %b, want 0001", out_a);
        end
        for (int k = 0; k < 4; k++) tick();
        total++;
        if (done_cnt_a != 1) begin
            bad++;
            $display("FAIL async_done_count: got %0d, want 1", done_cnt_a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap0();
        test_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
